multi_lick_logger: RTL and testbench

- Parametrised multi-channel successor to the single-channel lick recorder.
- While the behaviour trigger (trig) is high, samples NUM_CH lick lines on each rising edge of the imaging frame sync.
- Packs samples into 16-bit words and queues them in an internal FIFO that the host-pipe logic drains with a read strobe.
- Adds partial-word flush at session end, overflow detection, and an occupancy count. Single clock domain.

---
 rtl/multi_lick_logger.sv | 226 ++++++++++++++++++++++
 tb/tb_multi_lick_logger.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_lick_logger.sv
// Multi-channel lick logger. Samples NUM_CH lick lines on each frame-sync edge while trig
// is high, packs them into 16-bit words and queues them in an internal FIFO.
// Latency: pin sync edge to sample <= SYNC_STAGES+2 clk; sample to word_count +2 clk.
// Backpressure: none upstream. When the FIFO is full a committed word is dropped and
// overflow is set. The host pops words with rd_en; rd_en is ignored when the FIFO is empty.
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   trig               session enable (clk domain)
//   sync, lick         asynchronous frame sync and lick lines (bit c = channel c)
//   rd_en              pop strobe; rd_data/rd_valid respond on the following cycle
//   word_count         FIFO occupancy in words
//   sample_count       syncs sampled this session (saturating)
//   overflow           sticky drop flag, cleared at session start
//   recording          high while waiting for / sampling sync edges
module multi_lick_logger #(
  parameter int NUM_CH      = 4,
  parameter int DEPTH_LOG2  = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trig,
  input  logic                  sync,
  input  logic [NUM_CH-1:0]     lick,
  input  logic                  rd_en,
  output logic [15:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic [31:0]           sample_count,
  output logic                  overflow,
  output logic                  recording
);

  localparam int SPW   = 16 / NUM_CH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0]          SLOT_LAST = 4'(SPW - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_SYNC = 2'd1;
  localparam logic [1:0] S_FLUSH     = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronisers. sync and lick use the same depth, so a lick value that
  // is stable when sync rises is the value seen on the detected edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_sr_q;
  logic [NUM_CH-1:0]      lick_sr_q [SYNC_STAGES];
  logic                   sync_prev_q;
  logic                   sync_s;
  logic [NUM_CH-1:0]      lick_s;
  logic                   sync_edge;

  assign sync_s    = sync_sr_q[SYNC_STAGES-1];
  assign lick_s    = lick_sr_q[SYNC_STAGES-1];
  assign sync_edge = sync_s & ~sync_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_sr_q   <= '0;
      sync_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        lick_sr_q[i] <= '0;
      end
    end else begin
      sync_sr_q    <= {sync_sr_q[SYNC_STAGES-2:0], sync};
      sync_prev_q  <= sync_s;
      lick_sr_q[0] <= lick;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        lick_sr_q[i] <= lick_sr_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Session FSM and packer
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [15:0] packer_q, packer_d;
  logic        commit_q, commit_d;
  logic [15:0] commit_word_q, commit_word_d;
  logic [31:0] sample_cnt_q, sample_cnt_d;
  logic        clear;
  logic [15:0] word_nxt;
  logic [3:0]  lsb;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    packer_d      = packer_q;
    commit_d      = 1'b0;
    commit_word_d = commit_word_q;
    sample_cnt_d  = sample_cnt_q;
    clear         = 1'b0;
    word_nxt      = packer_q;
    lsb           = 4'(slot_q * NUM_CH);

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          clear        = 1'b1;
          slot_d       = '0;
          packer_d     = '0;
          sample_cnt_d = '0;
          state_d      = S_WAIT_SYNC;
        end
      end

      S_WAIT_SYNC: begin
        // trig has priority: an edge arriving as the session ends is discarded.
        if (!trig) begin
          state_d = (slot_q != 4'd0) ? S_FLUSH : S_IDLE;
        end else if (sync_edge) begin
          word_nxt[lsb +: NUM_CH] = lick_s;
          if (sample_cnt_q != 32'hFFFF_FFFF) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
          end
          if (slot_q == SLOT_LAST) begin
            commit_d      = 1'b1;
            commit_word_d = word_nxt;
            packer_d      = '0;
            slot_d        = '0;
          end else begin
            packer_d = word_nxt;
            slot_d   = slot_q + 4'd1;
          end
        end
      end

      S_FLUSH: begin
        // Packer is zeroed after every commit, so unused upper slots are already 0.
        commit_d      = 1'b1;
        commit_word_d = packer_q;
        packer_d      = '0;
        slot_d        = '0;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      packer_q      <= '0;
      commit_q      <= 1'b0;
      commit_word_q <= '0;
      sample_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      packer_q      <= packer_d;
      commit_q      <= commit_d;
      commit_word_q <= commit_word_d;
      sample_cnt_q  <= sample_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Word FIFO. Session start clears it and wins over any same-cycle push/pop
  // (a flush word still in flight when trig re-asserts is discarded).
  // ---------------------------------------------------------------------------
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  overflow_q;
  logic [15:0]           rd_data_q;
  logic                  rd_valid_q;
  logic                  push_req, pop, full, push, drop;

  assign push_req = commit_q & ~clear;
  assign pop      = rd_en & (cnt_q != '0) & ~clear;
  assign full     = (cnt_q == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= commit_word_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= mem[rd_ptr_q];
      end
      if (clear) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign word_count   = cnt_q;
  assign sample_count = sample_cnt_q;
  assign overflow     = overflow_q;
  assign recording    = (state_q == S_WAIT_SYNC);

endmodule

// File: tb/tb_multi_lick_logger.sv
// Directed bench for multi_lick_logger with NUM_CH=4, DEPTH_LOG2=2, SYNC_STAGES=2.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_multi_lick_logger;

  logic        clk;
  logic        reset_n;
  logic        trig;
  logic        sync;
  logic [3:0]  lick;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [2:0]  word_count;
  logic [31:0] sample_count;
  logic        overflow;
  logic        recording;

  int n_chk = 0;
  int n_bad = 0;
  logic        cap_vld;
  logic [15:0] cap_dat;

  multi_lick_logger #(
    .NUM_CH(4), .DEPTH_LOG2(2), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trig(trig), .sync(sync), .lick(lick),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .word_count(word_count), .sample_count(sample_count),
    .overflow(overflow), .recording(recording)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One sync pulse carrying lick value v. If pop is set, rd_en is held for exactly
  // the cycle in which a word committed by this sample is written to the FIFO.
  task automatic pulse(input logic [3:0] v, input logic pop);
    lick = v;
    sync = 1'b1;
    tick(3);
    rd_en = pop;
    tick(1);
    rd_en = 1'b0;
    cap_vld = rd_valid;
    cap_dat = rd_data;
    sync = 1'b0;
    tick(2);
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    cap_vld = rd_valid;
    cap_dat = rd_data;
  endtask

  task automatic word4(input logic [3:0] v);
    for (int i = 0; i < 4; i++) pulse(v, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; trig = 1'b0; sync = 1'b0; lick = '0; rd_en = 1'b0;
    cap_vld = 1'b0; cap_dat = '0;
    tick(3);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_sc", sample_count, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_rec", 32'(recording), 32'd0);
    check("rst_vld", 32'(rd_valid), 32'd0);
    check("rst_dat", 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Syncs with trig low are ignored.
    pulse(4'h7, 1'b0);
    pulse(4'h7, 1'b0);
    check("idle_sc", sample_count, 32'd0);
    check("idle_wc", 32'(word_count), 32'd0);

    // Basic word: samples 1,2,3,4 -> 0x4321.
    trig = 1'b1;
    tick(2);
    check("rec_on", 32'(recording), 32'd1);
    pulse(4'h1, 1'b0); pulse(4'h2, 1'b0); pulse(4'h3, 1'b0); pulse(4'h4, 1'b0);
    check("w1_wc", 32'(word_count), 32'd1);
    check("w1_sc", sample_count, 32'd4);
    do_pop();
    check("w1_vld", 32'(cap_vld), 32'd1);
    check("w1_dat", 32'(cap_dat), 32'h4321);
    tick(1);
    check("w1_vld_pulse", 32'(rd_valid), 32'd0);
    check("w1_hold", 32'(rd_data), 32'h4321);
    check("w1_empty", 32'(word_count), 32'd0);

    // Partial-word flush: 0xA, 0x5 then trig low -> 0x005A.
    pulse(4'hA, 1'b0); pulse(4'h5, 1'b0);
    trig = 1'b0;
    tick(4);
    check("fl_rec", 32'(recording), 32'd0);
    check("fl_wc", 32'(word_count), 32'd1);
    check("fl_sc", sample_count, 32'd6);
    do_pop();
    check("fl_dat", 32'(cap_dat), 32'h005A);

    // Overflow: five words into a four-deep FIFO.
    trig = 1'b1;
    tick(2);
    check("s2_sc", sample_count, 32'd0);
    for (int k = 1; k <= 5; k++) word4(4'(k));
    check("ov_wc", 32'(word_count), 32'd4);
    check("ov_flag", 32'(overflow), 32'd1);
    check("ov_sc", sample_count, 32'd20);
    for (int k = 1; k <= 4; k++) begin
      do_pop();
      check("ov_pop_vld", 32'(cap_vld), 32'd1);
      check("ov_pop_dat", 32'(cap_dat), 32'h1111 * k);
    end
    do_pop();
    check("ov_empty_vld", 32'(cap_vld), 32'd0);
    check("ov_empty_hold", 32'(cap_dat), 32'h4444);
    check("ov_sticky", 32'(overflow), 32'd1);

    // New session clears overflow and occupancy.
    trig = 1'b0;
    tick(3);
    trig = 1'b1;
    tick(2);
    check("s3_ovf", 32'(overflow), 32'd0);
    check("s3_wc", 32'(word_count), 32'd0);

    // Push coincident with pop at 3 words, then at full.
    word4(4'h6); word4(4'h7); word4(4'h8);
    check("co_wc3", 32'(word_count), 32'd3);
    pulse(4'h9, 1'b0); pulse(4'h9, 1'b0); pulse(4'h9, 1'b0); pulse(4'h9, 1'b1);
    check("co3_vld", 32'(cap_vld), 32'd1);
    check("co3_dat", 32'(cap_dat), 32'h6666);
    check("co3_wc", 32'(word_count), 32'd3);
    word4(4'hA);
    check("co_full", 32'(word_count), 32'd4);
    pulse(4'hB, 1'b0); pulse(4'hB, 1'b0); pulse(4'hB, 1'b0); pulse(4'hB, 1'b1);
    check("cof_dat", 32'(cap_dat), 32'h7777);
    check("cof_wc", 32'(word_count), 32'd4);
    check("cof_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      do_pop();
      check("cof_drain", 32'(cap_dat), (k == 0) ? 32'h8888 : (k == 1) ? 32'h9999 :
                                      (k == 2) ? 32'hAAAA : 32'hBBBB);
    end

    // trig falling in the same cycle as a sync edge discards that sample.
    trig = 1'b0;
    tick(3);
    trig = 1'b1;
    tick(2);
    pulse(4'h3, 1'b0);
    lick = 4'hF;
    sync = 1'b1;
    tick(2);
    trig = 1'b0;
    tick(2);
    sync = 1'b0;
    tick(5);
    check("tf_sc", sample_count, 32'd1);
    check("tf_wc", 32'(word_count), 32'd1);
    do_pop();
    check("tf_dat", 32'(cap_dat), 32'h0003);

    // Reset mid-word aborts with no flush; next session has no stale bits.
    trig = 1'b1;
    tick(2);
    pulse(4'hF, 1'b0); pulse(4'hF, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mr_sc", sample_count, 32'd0);
    check("mr_rec", 32'(recording), 32'd0);
    check("mr_wc", 32'(word_count), 32'd0);
    trig = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    check("mr_noflush", 32'(word_count), 32'd0);
    trig = 1'b1;
    tick(2);
    pulse(4'h5, 1'b0); pulse(4'h6, 1'b0); pulse(4'h7, 1'b0); pulse(4'h8, 1'b0);
    check("mr_wc1", 32'(word_count), 32'd1);
    do_pop();
    check("mr_dat", 32'(cap_dat), 32'h8765);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
